adc_capture_interface: RTL and testbench
========================================

Name: adc_capture_interface

Overview:
- Receive side of the WM8731 digital audio interface, the counterpart of the DAC transmit path.
- Acts as frame master on the ADC channel: generates AUD_ADCLRCK frame pulses and deserializes AUD_ADCDAT in DSP mode (left word, then right word, MSB first).
- Presents each stereo sample pair with a one-cycle valid strobe.
- On request, records a mono mix of the samples into the 16-bit audio RAM, one write per frame, until the RAM is full.

Parameters:
- DATA_WIDTH, 16, bits per channel word.
- FRAME_BCLKS, 250, AUD_BCLK cycles per frame; must be >= 2*DATA_WIDTH+3, otherwise elaboration error.
- MEM_DEPTH, 240255, number of RAM words recorded per capture.
- ADDR_WIDTH, 18, RAM address width; 2**ADDR_WIDTH >= MEM_DEPTH.

Ports:
- AUD_BCLK  in  1  bit clock; the only clock. All registers update on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- AUD_ADCDAT  in  1  serial ADC data from codec.
- AUD_ADCLRCK  out  1  frame-sync pulse to codec.
- record_start  in  1  one-cycle request to begin a capture.
- record_abort  in  1  terminates a capture immediately.
- left_sample  out  DATA_WIDTH  last left word, two's complement.
- right_sample  out  DATA_WIDTH  last right word.
- sample_valid  out  1  one-cycle strobe; left/right updated.
- mem_wr_en  out  1  RAM write enable.
- mem_wr_addr  out  ADDR_WIDTH  RAM write address.
- mem_wr_data  out  DATA_WIDTH  mono sample to RAM.
- record_busy  out  1  high in ARM and RECORD states.
- record_done  out  1  one-cycle pulse when the capture completes.

Behaviour:
Reset:
- All outputs 0; shift register 0; state IDLE; write address 0.
- Frame counter fcnt resets to FRAME_BCLKS-1.

Framing:
- fcnt counts 0..FRAME_BCLKS-1 and wraps.
- AUD_ADCLRCK is registered and high for exactly the cycle in which fcnt==0.
- The first pulse follows the first rising edge after reset deasserts.

Deserialize:
- On each edge where the current fcnt is in 1..2*DATA_WIDTH, shift AUD_ADCDAT into the LSB of a 2*DATA_WIDTH shift register.
- On the edge where fcnt==2*DATA_WIDTH+1:
  - left_sample <= upper word; right_sample <= lower word.
  - sample_valid <= 1 for one cycle.
- Edges at any other fcnt value leave the shift register untouched.
- Latency: sample_valid is high in the cycle fcnt==2*DATA_WIDTH+2.

Mono mix:
- m = (sext(L)+sext(R)) >>> 1, computed at DATA_WIDTH+1 bits.
- Arithmetic shift, rounding toward minus infinity.
- Cannot overflow.

Record FSM (states IDLE, ARM, RECORD, DONE):
- IDLE: record_start -> ARM. record_start in any other state is ignored.
- ARM: wait for fcnt==0 so that the first written sample comes from a complete frame, then go to RECORD with address 0.
- RECORD: on the cycle after each sample_valid:
  - mem_wr_en=1 for one cycle, with mem_wr_addr = current address and mem_wr_data = m.
  - The address then increments.
  - The write at MEM_DEPTH-1 moves the FSM to DONE; no address wrap occurs and no write is issued beyond MEM_DEPTH-1.
- DONE: record_done=1 for one cycle, then go to IDLE.
- record_abort in ARM or RECORD:
  - Go to IDLE on the next edge with no further writes and no record_done.
  - The address resets to 0.
  - Abort wins over a simultaneous write.
- Asserting reset mid-capture returns the block to the reset values; a partial capture is simply abandoned.
- Framing and deserialization run continuously, independent of the FSM state.

Decomposition:
- Shared package audio_if_pkg holds:
  - FSM state enum (IDLE, ARM, RECORD, DONE).
  - Constants DATA_WIDTH=16 and FRAME_BCLKS=250, shared with the DAC transmit path.
  - MEM_DEPTH=240255.
- One sub-module is natural: adc_frame_deserializer, covering fcnt, AUD_ADCLRCK, the shift register and sample_valid.
- The top level holds the mono mix and the record FSM.

Test Plan:
- Reset: hold reset_n=0 -> all outputs 0. Release -> AUD_ADCLRCK high 1 cycle, then again every 250 cycles.
- Single frame: drive L=0x8001, R=0x7FFE MSB-first in fcnt 1..32 -> left_sample=0x8001, right_sample=0x7FFE, sample_valid exactly 1 cycle at fcnt==34.
- Mix arithmetic: check each pair in RECORD.
  - L=0xFFFF, R=0x0001 -> mem_wr_data=0x0000.
  - L=0x8000, R=0x8000 -> 0x8000.
  - L=0x7FFF, R=0x7FFF -> 0x7FFF.
  - L=0xFFFF, R=0x0000 -> 0xFFFF.
- Full capture with MEM_DEPTH=4, record_start at fcnt=100:
  - No write until after the next fcnt==0.
  - Writes at addresses 0,1,2,3, one per frame.
  - record_done pulses once; record_busy falls; no fifth write.
- Abort: record_abort asserted in the same cycle as the second write -> no write, no record_done, IDLE. A following record_start restarts writing at address 0.
- Reset mid-capture: reset_n low during RECORD at address 2 -> outputs 0, state IDLE. After release, no writes without a new record_start.

Source files
------------

// File: rtl/audio_if_pkg.sv
// Shared audio-interface definitions used by the ADC capture and DAC transmit paths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package audio_if_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int FRAME_BCLKS = 250;
    localparam int MEM_DEPTH   = 240255;
    localparam int ADDR_WIDTH  = 18;

    // Capture controller states.
    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RECORD,
        DONE
    } rec_state_t;

endpackage

// File: rtl/adc_frame_deserializer.sv
// Frame master and DSP-mode deserializer: frame counter, AUD_ADCLRCK pulse, L/R word capture.
// Latency: sample_valid is high in the cycle fcnt == 2*DATA_WIDTH+2 of the frame carrying the words.
// Backpressure: none; the codec streams continuously and each pair is offered once per frame.
//
// Ports: AUD_BCLK/reset_n clock and async reset; AUD_ADCDAT serial in; AUD_ADCLRCK frame pulse out;
//        fcnt current frame position; left_sample/right_sample last words; sample_valid one-cycle strobe.
module adc_frame_deserializer #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRAME_BCLKS = 250
) (
    input  logic                           AUD_BCLK,
    input  logic                           reset_n,
    input  logic                           AUD_ADCDAT,
    output logic                           AUD_ADCLRCK,
    output logic [$clog2(FRAME_BCLKS)-1:0] fcnt,
    output logic [DATA_WIDTH-1:0]          left_sample,
    output logic [DATA_WIDTH-1:0]          right_sample,
    output logic                           sample_valid
);

    localparam int FW = $clog2(FRAME_BCLKS);
    localparam logic [FW-1:0] FCNT_LAST  = FW'(FRAME_BCLKS - 1);
    localparam logic [FW-1:0] SHIFT_LAST = FW'(2 * DATA_WIDTH);
    localparam logic [FW-1:0] CAPTURE_AT = FW'(2 * DATA_WIDTH + 1);

    // Both words plus the capture slot and the frame-sync slot must fit in one frame.
    generate
        if (FRAME_BCLKS < 2 * DATA_WIDTH + 3) begin : g_bad_frame
            $error("FRAME_BCLKS too small for two words per frame");
        end
    endgenerate

    logic [2*DATA_WIDTH-1:0] shift_reg;
    logic [FW-1:0]           fcnt_nxt;

    assign fcnt_nxt = (fcnt == FCNT_LAST) ? '0 : fcnt + FW'(1);

    always_ff @(posedge AUD_BCLK or negedge reset_n) begin
        if (!reset_n) begin
            // Starting at the last slot makes the first edge after reset open a frame.
            fcnt         <= FCNT_LAST;
            AUD_ADCLRCK  <= 1'b0;
            shift_reg    <= '0;
            left_sample  <= '0;
            right_sample <= '0;
            sample_valid <= 1'b0;
        end else begin
            fcnt         <= fcnt_nxt;
            // Registered so the pulse lines up with the cycle where fcnt == 0.
            AUD_ADCLRCK  <= (fcnt_nxt == '0);
            sample_valid <= 1'b0;
            if (fcnt != '0 && fcnt <= SHIFT_LAST) begin
                shift_reg <= {shift_reg[2*DATA_WIDTH-2:0], AUD_ADCDAT};
            end
            if (fcnt == CAPTURE_AT) begin
                left_sample  <= shift_reg[2*DATA_WIDTH-1:DATA_WIDTH];
                right_sample <= shift_reg[DATA_WIDTH-1:0];
                sample_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_capture_interface.sv
// WM8731 ADC receive path: stereo deserializer plus mono-mix recorder into audio RAM.
// Latency: one RAM write in the cycle after each sample_valid while recording.
// Backpressure: none; the RAM must accept one write per frame.
//
// Ports: AUD_BCLK/reset_n clock and async reset; AUD_ADCDAT/AUD_ADCLRCK codec serial link;
//        record_start/record_abort capture control; left/right_sample + sample_valid stereo output;
//        mem_wr_en/addr/data RAM write port; record_busy/record_done capture status.
module adc_capture_interface #(
    parameter int DATA_WIDTH  = audio_if_pkg::DATA_WIDTH,
    parameter int FRAME_BCLKS = audio_if_pkg::FRAME_BCLKS,
    parameter int MEM_DEPTH   = audio_if_pkg::MEM_DEPTH,
    parameter int ADDR_WIDTH  = audio_if_pkg::ADDR_WIDTH
) (
    input  logic                  AUD_BCLK,
    input  logic                  reset_n,
    input  logic                  AUD_ADCDAT,
    output logic                  AUD_ADCLRCK,
    input  logic                  record_start,
    input  logic                  record_abort,
    output logic [DATA_WIDTH-1:0] left_sample,
    output logic [DATA_WIDTH-1:0] right_sample,
    output logic                  sample_valid,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  record_busy,
    output logic                  record_done
);

    import audio_if_pkg::*;

    localparam int FW = $clog2(FRAME_BCLKS);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    generate
        if ((64'(1) << ADDR_WIDTH) < 64'(MEM_DEPTH)) begin : g_bad_addr
            $error("ADDR_WIDTH cannot address MEM_DEPTH words");
        end
    endgenerate

    logic [FW-1:0]         fcnt;
    logic [DATA_WIDTH:0]   mix_sum;
    logic [DATA_WIDTH-1:0] mix;
    logic [ADDR_WIDTH-1:0] wr_addr;
    rec_state_t            state;

    adc_frame_deserializer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .FRAME_BCLKS (FRAME_BCLKS)
    ) u_deser (
        .AUD_BCLK     (AUD_BCLK),
        .reset_n      (reset_n),
        .AUD_ADCDAT   (AUD_ADCDAT),
        .AUD_ADCLRCK  (AUD_ADCLRCK),
        .fcnt         (fcnt),
        .left_sample  (left_sample),
        .right_sample (right_sample),
        .sample_valid (sample_valid)
    );

    // One extra bit of headroom, then drop the LSB: arithmetic halving that floors and never overflows.
    assign mix_sum = {left_sample[DATA_WIDTH-1], left_sample} + {right_sample[DATA_WIDTH-1], right_sample};
    assign mix     = mix_sum[DATA_WIDTH:1];

    always_ff @(posedge AUD_BCLK or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            wr_addr     <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            record_busy <= 1'b0;
            record_done <= 1'b0;
        end else begin
            mem_wr_en   <= 1'b0;
            record_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (record_start) begin
                        state       <= ARM;
                        record_busy <= 1'b1;
                    end
                end
                ARM: begin
                    if (record_abort) begin
                        state       <= IDLE;
                        wr_addr     <= '0;
                        record_busy <= 1'b0;
                    end else if (fcnt == '0) begin
                        // Frame boundary: every word recorded from here on is complete.
                        state   <= RECORD;
                        wr_addr <= '0;
                    end
                end
                RECORD: begin
                    if (record_abort) begin
                        // Abort takes priority over a write due on the same edge.
                        state       <= IDLE;
                        wr_addr     <= '0;
                        record_busy <= 1'b0;
                    end else if (sample_valid) begin
                        mem_wr_en   <= 1'b1;
                        mem_wr_addr <= wr_addr;
                        mem_wr_data <= mix;
                        if (wr_addr == LAST_ADDR) begin
                            state       <= DONE;
                            wr_addr     <= '0;
                            record_busy <= 1'b0;
                            record_done <= 1'b1;
                        end else begin
                            wr_addr <= wr_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_capture_interface.sv
// Scoreboard bench for adc_capture_interface: random codec words, frame-level model of captures.
// Latency: n/a.
// Backpressure: n/a.
module tb_adc_capture_interface;

    localparam int DW = 16;
    localparam int FB = 250;
    localparam int MD = 4;
    localparam int AW = 18;

    logic          AUD_BCLK = 1'b0;
    logic          reset_n = 1'b0;
    logic          AUD_ADCDAT = 1'b0;
    logic          record_start = 1'b0;
    logic          record_abort = 1'b0;
    logic          AUD_ADCLRCK;
    logic [DW-1:0] left_sample;
    logic [DW-1:0] right_sample;
    logic          sample_valid;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic          record_busy;
    logic          record_done;

    adc_capture_interface #(
        .DATA_WIDTH  (DW),
        .FRAME_BCLKS (FB),
        .MEM_DEPTH   (MD),
        .ADDR_WIDTH  (AW)
    ) dut (
        .AUD_BCLK     (AUD_BCLK),
        .reset_n      (reset_n),
        .AUD_ADCDAT   (AUD_ADCDAT),
        .AUD_ADCLRCK  (AUD_ADCLRCK),
        .record_start (record_start),
        .record_abort (record_abort),
        .left_sample  (left_sample),
        .right_sample (right_sample),
        .sample_valid (sample_valid),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .record_busy  (record_busy),
        .record_done  (record_done)
    );

    always #5 AUD_BCLK = ~AUD_BCLK;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            last;
    } wr_t;

    int checks = 0;
    int errors = 0;
    int seen_done = 0;
    int exp_done = 0;
    int pos = FB - 1;           // frame slot of the current cycle, from elapsed edges since reset

    logic [2*DW-1:0] samp_q[$];
    logic [2*DW-1:0] dir_q[$];
    wr_t             wr_q[$];
    logic [2*DW-1:0] cur_word = '0;
    logic [2*DW-1:0] got_pair;
    wr_t             got_wr;
    bit              cap_armed = 0;
    bit              cap_rec = 0;
    bit              start_pend = 0;
    bit              abort_pend = 0;
    int              cap_idx = 0;

    // Mono reference: average of the two signed words, rounded toward minus infinity.
    function automatic logic [DW-1:0] mono(input logic [2*DW-1:0] w);
        shortint l;
        shortint r;
        int      s;
        l = w[2*DW-1:DW];
        r = w[DW-1:0];
        s = int'(l) + int'(r);
        return 16'(s >>> 1);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_ctl"}, 64'({AUD_ADCLRCK, sample_valid, mem_wr_en, record_busy, record_done, mem_wr_addr}), 64'd0);
        chk({name, "_dat"}, 64'({left_sample, right_sample, mem_wr_data}), 64'd0);
    endtask

    always @(posedge AUD_BCLK or negedge reset_n) begin
        if (!reset_n) pos <= FB - 1;
        else          pos <= (pos == FB - 1) ? 0 : pos + 1;
    end

    // Monitor: compares whatever the DUT presents against the scoreboard queues.
    always @(negedge AUD_BCLK) begin
        if (reset_n) begin
            chk("lrck", 64'(AUD_ADCLRCK), 64'(pos == 0));
            if (sample_valid) begin
                if (samp_q.size() == 0) begin
                    chk("sample_unexpected", 64'(sample_valid), 64'd0);
                end else begin
                    got_pair = samp_q.pop_front();
                    chk("left", 64'(left_sample), 64'(got_pair[2*DW-1:DW]));
                    chk("right", 64'(right_sample), 64'(got_pair[DW-1:0]));
                    chk("valid_slot", 64'(pos), 64'd34);
                end
            end
            if (record_done) seen_done++;
            if (mem_wr_en) begin
                if (wr_q.size() == 0) begin
                    chk("write_unexpected", 64'(mem_wr_en), 64'd0);
                end else begin
                    got_wr = wr_q.pop_front();
                    chk("wr_addr", 64'(mem_wr_addr), 64'(got_wr.addr));
                    chk("wr_data", 64'(mem_wr_data), 64'(got_wr.data));
                    chk("wr_done", 64'(record_done), 64'(got_wr.last));
                    chk("wr_slot", 64'(pos), 64'd35);
                end
            end else if (record_done) begin
                chk("done_unexpected", 64'(record_done), 64'd0);
            end
            if (pos == 36) begin
                chk("sample_missing", 64'(samp_q.size()), 64'd0);
                chk("write_missing", 64'(wr_q.size()), 64'd0);
                samp_q.delete();
                wr_q.delete();
            end
        end
    end

    // Drive one cycle and advance the frame-level capture model.
    task automatic drive_cycle();
        int p;
        p = pos;
        record_start = 1'b0;
        record_abort = 1'b0;
        if (p == 0) begin
            cur_word = (dir_q.size() > 0) ? dir_q.pop_front() : $urandom;
            samp_q.push_back(cur_word);
            if (cap_armed) begin
                cap_armed = 0;
                cap_rec   = 1;
                cap_idx   = 0;
            end
        end
        AUD_ADCDAT = (p >= 1 && p <= 2*DW) ? cur_word[2*DW-p] : 1'($urandom_range(0, 1));
        if (p == 34 && cap_rec) begin
            if (abort_pend) begin
                record_abort = 1'b1;
                abort_pend   = 0;
                cap_rec      = 0;
            end else begin
                wr_q.push_back('{addr: AW'(cap_idx), data: mono(cur_word), last: (cap_idx == MD - 1)});
                if (cap_idx == MD - 1) begin
                    cap_rec = 0;
                    exp_done++;
                end
                cap_idx++;
            end
        end
        if (p == 100 && start_pend) begin
            record_start = 1'b1;
            start_pend   = 0;
            if (!cap_armed && !cap_rec) cap_armed = 1;
        end
    endtask

    task automatic step();
        @(negedge AUD_BCLK);
        drive_cycle();
    endtask

    task automatic goto(input int p);
        for (int n = 0; n < FB + 10; n++) begin
            step();
            if (pos == p) return;
        end
        checks++;
        errors++;
        $display("FAIL goto_timeout got=%0d exp=%0d", pos, p);
    endtask

    task automatic do_reset_mid();
        @(posedge AUD_BCLK);
        #2 reset_n = 1'b0;
        record_start = 1'b0;
        record_abort = 1'b0;
        samp_q.delete();
        wr_q.delete();
        dir_q.delete();
        cap_armed  = 0;
        cap_rec    = 0;
        start_pend = 0;
        abort_pend = 0;
        #1 chk_zero("reset_mid");
        repeat (5) @(negedge AUD_BCLK);
        chk_zero("reset_hold");
        @(posedge AUD_BCLK);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge AUD_BCLK);
        chk_zero("reset");
        @(posedge AUD_BCLK);
        #2 reset_n = 1'b1;

        // Single directed frame.
        dir_q.push_back(32'h8001_7FFE);
        goto(40);
        chk("single_left", 64'(left_sample), 64'h8001);
        chk("single_right", 64'(right_sample), 64'h7FFE);
        goto(200);
        goto(200);
        chk("busy_idle", 64'(record_busy), 64'd0);

        // Full capture with mix corner cases; first write only after the next frame start.
        start_pend = 1;
        goto(100);
        dir_q.push_back(32'hFFFF_0001);
        dir_q.push_back(32'h8000_8000);
        dir_q.push_back(32'h7FFF_7FFF);
        dir_q.push_back(32'hFFFF_0000);
        for (int f = 0; f < MD; f++) begin
            goto(200);
            chk("busy_cap", 64'(record_busy), 64'd1);
        end
        goto(200);
        chk("busy_after", 64'(record_busy), 64'd0);
        chk("done_one", 64'(seen_done), 64'd1);
        goto(200);
        goto(200);

        // Abort on the second write, then a clean restart from address 0.
        start_pend = 1;
        goto(100);
        goto(200);
        goto(200);
        abort_pend = 1;
        goto(200);
        chk("busy_abort", 64'(record_busy), 64'd0);
        chk("done_abort", 64'(seen_done), 64'd1);
        start_pend = 1;
        goto(100);
        for (int f = 0; f < MD + 1; f++) goto(200);
        chk("done_restart", 64'(seen_done), 64'd2);
        chk("busy_restart", 64'(record_busy), 64'd0);

        // Reset while recording at address 2; nothing may be written afterwards.
        start_pend = 1;
        goto(100);
        for (int f = 0; f < 3; f++) goto(200);
        chk("addr_before_reset", 64'(mem_wr_addr), 64'd1);
        do_reset_mid();
        for (int f = 0; f < 4; f++) goto(200);
        chk("busy_post_reset", 64'(record_busy), 64'd0);

        chk("done_total", 64'(seen_done), 64'(exp_done));
        chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
